// File: rtl/fire_sensor_pkg.sv
// Shared types and default timing for the fire-sensor conditioning path.
// Defaults assume a 100 MHz system clock.
package fire_sensor_pkg;

    typedef enum logic [1:0] {
        SAFE    = 2'd0,
        FIRE    = 2'd1,
        HOLD    = 2'd2,
        LATCHED = 2'd3
    } fire_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms
    localparam int unsigned DEF_HOLD_CYCLES     = 300_000_000; // 3 s

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser, polarity correction and counter-based debounce of
// the raw flame pin, with one-cycle rise/fall pulses on the clean level.
module sensor_debounce
    import fire_sensor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit          RAW_ACTIVE_LOW  = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sensor_raw_i,
    output logic fire_level_o,
    output logic fire_rise_o,
    output logic fire_fall_o
);

    localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             s;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q, rise_q, fall_q;

    assign s = sync2_q ^ RAW_ACTIVE_LOW;

    // Sync flops reset to the pin level that reads as "no flame".
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= RAW_ACTIVE_LOW;
            sync2_q <= RAW_ACTIVE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sensor_raw_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            if (s == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= s;
                cnt_q   <= '0;
                rise_q  <= s;
                fall_q  <= ~s;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign fire_level_o = level_q;
    assign fire_rise_o  = rise_q;
    assign fire_fall_o  = fall_q;

endmodule

// File: rtl/fire_sensor_conditioner.sv
// Fire-sensor front end: debounced flame level feeding an alarm FSM with a
// minimum hold time and optional latch-until-acknowledge.
module fire_sensor_conditioner
    import fire_sensor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter bit          RAW_ACTIVE_LOW  = 1'b0,
    parameter bit          LATCH           = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_raw,
    input  logic       alarm_ack,
    output logic       fire_level,
    output logic       fire_rise,
    output logic       fire_fall,
    output logic       alarm,
    output logic [1:0] state
);

    localparam int unsigned       HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    fire_state_e       state_q;
    logic [HOLD_W-1:0] hold_q;
    logic              alarm_q;

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RAW_ACTIVE_LOW  (RAW_ACTIVE_LOW)
    ) u_debounce (
        .clk_i        (clk),
        .rst_i        (rst),
        .sensor_raw_i (sensor_raw),
        .fire_level_o (fire_level),
        .fire_rise_o  (fire_rise),
        .fire_fall_o  (fire_fall)
    );

    // alarm_q tracks "next state != SAFE" so it changes on the same edge as state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SAFE;
            hold_q  <= '0;
            alarm_q <= 1'b0;
        end else begin
            unique case (state_q)
                SAFE: begin
                    if (fire_level) begin
                        state_q <= FIRE;
                        alarm_q <= 1'b1;
                    end
                end
                FIRE: begin
                    if (!fire_level) begin
                        state_q <= HOLD;
                        hold_q  <= '0;
                    end
                end
                HOLD: begin
                    if (fire_level) begin
                        state_q <= FIRE;
                        hold_q  <= '0;
                    end else if (hold_q == HOLD_LAST) begin
                        state_q <= LATCH ? LATCHED : SAFE;
                        alarm_q <= LATCH;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                LATCHED: begin
                    if (fire_level) begin
                        state_q <= FIRE;
                    end else if (alarm_ack) begin
                        state_q <= SAFE;
                        alarm_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign alarm = alarm_q;
    assign state = state_q;

endmodule

// File: tb/tb_fire_sensor_conditioner.sv
// Randomized and directed checks of the fire-sensor conditioner against a
// window-based debounce model and a cycle-counting alarm model.
module tb_fire_sensor_conditioner;

    localparam int D = 4;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       raw = 1'b0;
    logic       raw_n;
    logic       ack = 1'b0;
    logic       fl_o    [3];
    logic       rise_o  [3];
    logic       fall_o  [3];
    logic       alarm_o [3];
    logic [1:0] state_o [3];

    assign raw_n = ~raw;

    // 0: reference config, 1: active-low pin fed the inverted pin, 2: no latch
    fire_sensor_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H),
                              .RAW_ACTIVE_LOW(1'b0), .LATCH(1'b1)) u_dut (
        .clk(clk), .rst(rst), .sensor_raw(raw), .alarm_ack(ack),
        .fire_level(fl_o[0]), .fire_rise(rise_o[0]), .fire_fall(fall_o[0]),
        .alarm(alarm_o[0]), .state(state_o[0]));

    fire_sensor_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H),
                              .RAW_ACTIVE_LOW(1'b1), .LATCH(1'b1)) u_dut_al (
        .clk(clk), .rst(rst), .sensor_raw(raw_n), .alarm_ack(ack),
        .fire_level(fl_o[1]), .fire_rise(rise_o[1]), .fire_fall(fall_o[1]),
        .alarm(alarm_o[1]), .state(state_o[1]));

    fire_sensor_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H),
                              .RAW_ACTIVE_LOW(1'b0), .LATCH(1'b0)) u_dut_nl (
        .clk(clk), .rst(rst), .sensor_raw(raw), .alarm_ack(ack),
        .fire_level(fl_o[2]), .fire_rise(rise_o[2]), .fire_fall(fall_o[2]),
        .alarm(alarm_o[2]), .state(state_o[2]));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: s is the pin two edges late; the level flips once the
    // last D samples all disagree with it. Alarm model counts cycles spent in HOLD.
    bit m_p1, m_p2, m_fl, m_rise, m_fall;
    bit win [D];
    int m_st  [2];
    int m_cih [2];
    bit s_smp, fl_prev, all_diff;

    always @(posedge clk) begin
        if (rst) begin
            m_p1 = 0; m_p2 = 0; m_fl = 0; m_rise = 0; m_fall = 0;
            for (int i = 0; i < D; i++) win[i] = 0;
            for (int v = 0; v < 2; v++) begin m_st[v] = 0; m_cih[v] = 0; end
        end else begin
            s_smp = m_p2; m_p2 = m_p1; m_p1 = raw;
            fl_prev = m_fl;
            for (int i = D - 1; i > 0; i--) win[i] = win[i-1];
            win[0] = s_smp;
            all_diff = 1;
            for (int i = 0; i < D; i++) if (win[i] == m_fl) all_diff = 0;
            m_rise = 0; m_fall = 0;
            if (all_diff) begin
                m_fl = ~m_fl;
                if (m_fl) m_rise = 1; else m_fall = 1;
            end
            for (int v = 0; v < 2; v++) begin
                case (m_st[v])
                    0: if (fl_prev) m_st[v] = 1;
                    1: if (!fl_prev) begin m_st[v] = 2; m_cih[v] = 1; end
                    2: if (fl_prev) m_st[v] = 1;
                       else if (m_cih[v] == H) m_st[v] = (v == 0) ? 3 : 0;
                       else m_cih[v]++;
                    3: if (fl_prev) m_st[v] = 1;
                       else if (ack) m_st[v] = 0;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int j = 0; j < 3; j++) begin
                check_val($sformatf("level%0d", j), fl_o[j], m_fl);
                check_val($sformatf("rise%0d", j), rise_o[j], m_rise);
                check_val($sformatf("fall%0d", j), fall_o[j], m_fall);
                check_val($sformatf("state%0d", j), state_o[j], m_st[(j == 2) ? 1 : 0]);
                check_val($sformatf("alarm%0d", j), alarm_o[j], (m_st[(j == 2) ? 1 : 0] != 0));
            end
        end
    end

    // Edges until the reference DUT reports the wanted state; -1 if never.
    task automatic wait_state(input int want, output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (state_o[0] == 2'(want)) begin
                n = i;
                break;
            end
        end
    endtask

    int n;
    int run_left;
    bit glitch_seen;

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk) rst = 1'b0;

        // idle
        repeat (20) @(negedge clk);
        check_val("idle_state", state_o[0], 0);
        check_val("idle_alarm", alarm_o[0], 0);

        // glitch of 3 cycles must be rejected
        raw = 1'b1;
        repeat (3) @(negedge clk);
        raw = 1'b0;
        glitch_seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (fl_o[0] || alarm_o[0] || rise_o[0]) glitch_seen = 1;
        end
        check_val("glitch", glitch_seen, 0);

        // detect: alarm D+3 edges after the pin rises
        @(negedge clk) raw = 1'b1;
        wait_state(1, n);
        check_val("detect_lat", n, D + 3);
        check_val("detect_alarm", alarm_o[0], 1);

        // fall -> HOLD for exactly H cycles -> LATCHED, cleared by an ack pulse
        @(negedge clk) raw = 1'b0;
        wait_state(2, n);
        check_val("hold_entry", n, D + 3);
        wait_state(3, n);
        check_val("hold_len", n, H);
        repeat (3) @(negedge clk);
        check_val("latched_stays", state_o[0], 3);
        ack = 1'b1;
        wait_state(0, n);
        check_val("ack_clear", n, 1);
        @(negedge clk) ack = 1'b0;

        // refire on the last hold cycle goes back to FIRE
        raw = 1'b1;
        wait_state(1, n);
        check_val("refire_detect", n, D + 3);
        @(negedge clk) raw = 1'b0;
        wait_state(2, n);
        check_val("refire_hold_in", n, D + 3);
        @(posedge clk);
        @(negedge clk) raw = 1'b1;
        wait_state(1, n);
        check_val("refire_lastcyc", n, 7);

        // ack held high: no effect in FIRE/HOLD, immediate clear in LATCHED
        @(negedge clk) begin ack = 1'b1; raw = 1'b0; end
        wait_state(2, n);
        check_val("ackhold_hold_in", n, D + 3);
        repeat (4) @(posedge clk);
        @(negedge clk) raw = 1'b1;
        wait_state(1, n);
        check_val("ackhold_refire", n, 7);
        @(negedge clk) raw = 1'b0;
        wait_state(2, n);
        check_val("ackhold_hold2", n, D + 3);
        wait_state(3, n);
        check_val("ackhold_full_hold", n, H);
        wait_state(0, n);
        check_val("ackhold_clear", n, 1);
        @(negedge clk) ack = 1'b0;

        // reset mid-FIRE with the pin still asserted
        raw = 1'b1;
        wait_state(1, n);
        check_val("pre_rst_fire", n, D + 3);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check_val("rst_state", state_o[0], 0);
        check_val("rst_alarm", alarm_o[0], 0);
        check_val("rst_level_al", fl_o[1], 0);
        @(negedge clk) rst = 1'b0;
        wait_state(1, n);
        check_val("rst_redetect", n, D + 3);
        check_val("pol_alarm", alarm_o[1], 1);

        // randomized runs of pin levels, sparse acks and resets
        run_left = 0;
        repeat (2000) begin
            @(negedge clk);
            if (run_left == 0) begin
                raw = 1'($urandom_range(0, 1));
                run_left = $urandom_range(1, 14);
            end
            run_left--;
            ack = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk) begin rst = 1'b0; ack = 1'b0; end
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

endmodule
